// File: rtl/opl2_op_scheduler_if.sv
// Host key-on write bus plus the per-operator issue strobe toward the EG/PG pipeline.
// master: host / pipeline side; slave: the scheduler.
interface opl2_op_scheduler_if #(
  parameter int OP_NUM_WIDTH = 5
);
  logic                    key_wr_en;
  logic [OP_NUM_WIDTH-1:0] key_wr_op;
  logic                    key_wr_val;
  logic                    sample_clk_en;
  logic [OP_NUM_WIDTH-1:0] op_num;
  logic                    key_on_p0;

  modport master (
    output key_wr_en, key_wr_op, key_wr_val,
    input  sample_clk_en, op_num, key_on_p0
  );

  modport slave (
    input  key_wr_en, key_wr_op, key_wr_val,
    output sample_clk_en, op_num, key_on_p0
  );
endinterface

// File: rtl/opl2_op_scheduler.sv
// Per-sample operator sequencer: issues op 0..NUM_OPS-1 every OP_SPACING clocks,
// owns the key-on register file and the global envelope timer.
module opl2_op_scheduler #(
  parameter int NUM_OPS         = 18,
  parameter int OP_NUM_WIDTH    = 5,
  parameter int CLKS_PER_SAMPLE = 256,
  parameter int OP_SPACING      = 4,
  parameter int EG_TIMER_WIDTH  = 18
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  opl2_op_scheduler_if.slave        bus,
  output logic [EG_TIMER_WIDTH-1:0] eg_timer,
  output logic                      busy,
  output logic                      sample_done
);

  if ((NUM_OPS * OP_SPACING + 3 > CLKS_PER_SAMPLE) || (NUM_OPS > 2**OP_NUM_WIDTH) ||
      (OP_SPACING < 4)) begin : g_bad_params
    $error("opl2_op_scheduler: inconsistent NUM_OPS/OP_SPACING/CLKS_PER_SAMPLE/OP_NUM_WIDTH");
  end

  localparam int CNT_W = $clog2(CLKS_PER_SAMPLE);
  localparam int SUB_W = $clog2(OP_SPACING + 4);

  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [SUB_W-1:0]        GAP_LAST   = SUB_W'(OP_SPACING - 2);
  localparam logic [SUB_W-1:0]        DRAIN_LAST = SUB_W'(2);
  localparam logic [OP_NUM_WIDTH-1:0] OP_LAST    = OP_NUM_WIDTH'(NUM_OPS - 1);
  localparam logic [OP_NUM_WIDTH:0]   OP_LIMIT   = (OP_NUM_WIDTH + 1)'(NUM_OPS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;

  logic [2:0]                state, state_nxt;
  logic [CNT_W-1:0]          sample_cnt;
  logic [SUB_W-1:0]          sub_cnt;
  logic [OP_NUM_WIDTH-1:0]   op_cnt;
  logic [NUM_OPS-1:0]        key;
  logic                      eg_toggle;
  logic [EG_TIMER_WIDTH-1:0] eg_count;
  logic                      sweep_start;
  logic                      key_wr_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ISSUE;
      ISSUE:   state_nxt = (op_cnt == OP_LAST) ? DRAIN : GAP;
      GAP:     if (sub_cnt == GAP_LAST) state_nxt = ISSUE;
      DRAIN:   if (sub_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = WAIT;
      WAIT:    if (sample_cnt == CNT_LAST) state_nxt = enable ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sweep_start = (state_nxt == ISSUE) && (state != GAP);
  assign key_wr_hit  = bus.key_wr_en && ({1'b0, bus.key_wr_op} < OP_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      sub_cnt    <= '0;
      op_cnt     <= '0;
    end else begin
      state   <= state_nxt;
      sub_cnt <= (state_nxt != state) ? '0 : sub_cnt + 1'b1;
      if (state == IDLE || sample_cnt == CNT_LAST)
        sample_cnt <= '0;
      else
        sample_cnt <= sample_cnt + 1'b1;
      if (state_nxt == ISSUE)
        op_cnt <= (state == GAP) ? op_cnt + 1'b1 : '0;
    end
  end

  // eg_timer latches the pre-increment count, so sweep n sees floor(n/2).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eg_toggle <= 1'b0;
      eg_count  <= '0;
      eg_timer  <= '0;
    end else if (sweep_start) begin
      eg_toggle <= ~eg_toggle;
      eg_timer  <= eg_count;
      if (eg_toggle)
        eg_count <= eg_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      key <= '0;
    else if (key_wr_hit)
      key[bus.key_wr_op] <= bus.key_wr_val;
  end

  assign bus.sample_clk_en = (state == ISSUE);
  assign bus.op_num        = op_cnt;
  assign bus.key_on_p0     = (state == ISSUE) && key[op_cnt];
  assign busy              = (state == ISSUE) || (state == GAP) || (state == DRAIN) ||
                             (state == DONE);
  assign sample_done       = (state == DONE);

endmodule
